// File: rtl/param_sync_fifo_pkg.sv
// Shared width helpers and read-mode constants for the parametrised sync FIFO.
package fifo_pkg;

   localparam int FWFT_OFF = 0;
   localparam int FWFT_ON  = 1;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

   // One extra bit over the address distinguishes full from empty.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/param_sync_fifo_mem.sv
// Register array: one synchronous write port, one asynchronous read address.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 8
) (
   input  logic                      clk,
   input  logic                      wr_en,
   input  logic [addr_w(DEPTH)-1:0]  wr_addr,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic [addr_w(DEPTH)-1:0]  rd_addr,
   output logic [DATA_W-1:0]         rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy count, almost flags, error pulses and optional FWFT read.
module param_sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_W   = 4,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1,
   parameter int FWFT     = FWFT_OFF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       rd_en,
   output logic [DATA_W-1:0]          data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = addr_w(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
   localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic              wr_acc, rd_acc;
   logic [DATA_W-1:0] rd_data;

   // Flags decode only the registered pointers.
   assign count        = wr_ptr - rd_ptr;
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   assign rd_acc = rd_en && !empty;
   assign wr_acc = wr_en && (!full || rd_acc);

   fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (data_in),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         overflow  <= wr_en && !wr_acc;
         underflow <= rd_en && !rd_acc;
      end
   end

   generate
      if (FWFT == FWFT_ON) begin : g_fwft
         assign data_out = rd_data;
      end else begin : g_reg
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)      data_out <= '0;
            else if (rd_acc) data_out <= rd_data;
         end
      end
   endgenerate

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO; the next generation of the team's linear synchronous FIFO. It adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty flags, overflow and underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It sits between a single-clock producer and consumer as the standard buffering primitive.

## Interface
Parameters:
- DATA_W, 4: data width in bits (≥1)
- DEPTH, 8: number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- FWFT, 0: 0 = registered read (latency 1); 1 = first-word-fall-through

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- data_in  in  DATA_W  write data
- rd_en  in  1  read request (pop)
- data_out  out  DATA_W  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: a write was rejected
- underflow  out  1  one-cycle pulse: a read was rejected

## Operation
- Storage is a DEPTH×DATA_W array. wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide; the low bits address the array and the MSB is the wrap bit. Pointers wrap naturally modulo 2·DEPTH.
- count = wr_ptr − rd_ptr, taken modulo 2^(ADDR_W+1). full, empty and the almost flags decode count.
- A write is accepted iff wr_en && (!full || rd_accepted). A rejected write sets overflow for the next cycle; the array and pointers are unchanged.
- A read is accepted iff rd_en && !empty. A rejected read sets underflow for the next cycle.
- Simultaneous read and write at full: both are accepted, count stays at DEPTH, and the written word lands in the slot just freed.
- Simultaneous read and write at empty: the write is accepted, the read is rejected, and underflow pulses.
- FWFT=0: on an accepted read, data_out ← mem[rd_ptr] at the same edge. Otherwise data_out holds its value.
- FWFT=1: data_out = mem[rd_ptr] continuously. It is valid whenever !empty, and rd_en acknowledges the shown word. data_out is don't-care while empty.
- Reset, asynchronous and effective at any time including mid-transfer: pointers 0, count 0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0 when FWFT=0. Array contents are not reset and not guaranteed after reset.

## Timing
- Flags and count reflect the state after the most recent rising edge; they are decoded from registered pointers, with no combinational path from wr_en or rd_en.
- Write to empty: empty deasserts 1 cycle after the write edge. With FWFT=1, the word appears on data_out in that same cycle.
- FWFT=0 read latency: 1 cycle from the rd_en edge to data_out.
- overflow and underflow are registered pulses, high for exactly the cycle after the offending edge.
- Sustained throughput is 1 write and 1 read per cycle.

## Structure
- Package fifo_pkg holds the ptr_w/addr_w width functions based on $clog2, and the FWFT mode constants.
- Sub-module fifo_mem: a dual-port register array with one synchronous write port and one asynchronous read address. The top level owns the pointers, flags and the output register.

## Test plan
- Reset pulse (low for 1 ns mid-cycle) → empty=1, full=0, count=0, almost_empty=1, data_out=0.
- DEPTH=8, FWFT=0: write 1..8 on consecutive cycles → count steps 1..8; almost_full high at count 7; full high after the 8th write. A 9th write with value 9 → overflow pulses once, count stays 8.
- Read 8 words → data_out = 1..8 in order, each 1 cycle after its rd_en. A 9th read → underflow pulses, data_out holds 8.
- Fill to 8, then write 10 and read together for 3 cycles → count stays 8, no overflow. Draining gives 4,5,6,7,8,10,10,10, confirming wrap-around is correct.
- FWFT=1: write 5 → data_out=5 while empty=0 on the next cycle. Write 6, then rd_en → data_out=6.
- Write 3 words, assert reset mid-stream → all outputs return to reset values immediately. The next write/read returns the new data only.
